mem_bus_sequencer: RTL and testbench

Parametrised successor to the top-level RAM bus glue. It owns the shared SRAM port and passes it between three masters: the flash loader, the CPU and the diagnostics engine. A registered mode FSM replaces the ad-hoc read_complete/halt muxing and adds a halt handshake that waits for the CPU bus to go quiet. It also generalises the single hard-wired VRAM window into NUM_WINDOWS runtime-programmable mirror windows that feed the dual-port video RAMs.

---
 rtl/mem_bus_sequencer_pkg.sv | 24 ++
 rtl/mem_bus_sequencer_mirror_window_match.sv | 83 ++++++++
 rtl/mem_bus_sequencer.sv | 141 ++++++++++++++
 tb/tb_mem_bus_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_sequencer_pkg.sv
// Shared definitions for the SRAM bus sequencer: mode encoding and the
// helper that sizes window index ports.
package mem_bus_sequencer_pkg;

  localparam logic [2:0] LOAD_ENC      = 3'd0;
  localparam logic [2:0] RUN_ENC       = 3'd1;
  localparam logic [2:0] HALT_WAIT_ENC = 3'd2;
  localparam logic [2:0] HALTED_ENC    = 3'd3;
  localparam logic [2:0] RESUME_ENC    = 3'd4;

  typedef enum logic [2:0] {
    LOAD      = LOAD_ENC,
    RUN       = RUN_ENC,
    HALT_WAIT = HALT_WAIT_ENC,
    HALTED    = HALTED_ENC,
    RESUME    = RESUME_ENC
  } seq_state_t;

  // A single window still needs a one-bit index port.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_bus_sequencer_mirror_window_match.sv
// Programmable mirror windows: snoops SRAM writes and forwards hits in any
// enabled window to the matching dual-port video RAM, one cycle later.
module mirror_window_match
  import mem_bus_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_WINDOWS = 4,
  parameter int MIRROR_AW   = 11
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [ADDR_WIDTH-1:0]              ram_addr,
  input  logic [DATA_WIDTH-1:0]              ram_din,
  input  logic                               ram_we,
  input  logic                               win_wr,
  input  logic [idx_width(NUM_WINDOWS)-1:0]  win_idx,
  input  logic [ADDR_WIDTH-1:0]              win_start,
  input  logic [ADDR_WIDTH-1:0]              win_end,
  output logic                               mirror_we,
  output logic [idx_width(NUM_WINDOWS)-1:0]  mirror_sel,
  output logic [MIRROR_AW-1:0]               mirror_addr,
  output logic [DATA_WIDTH-1:0]              mirror_din
);

  localparam int IW = idx_width(NUM_WINDOWS);

  logic [ADDR_WIDTH-1:0] win_lo [NUM_WINDOWS];
  logic [ADDR_WIDTH-1:0] win_hi [NUM_WINDOWS];
  logic [NUM_WINDOWS-1:0] hit;
  logic                  hit_any;
  logic [IW-1:0]         hit_idx;
  logic [ADDR_WIDTH-1:0] hit_base;
  logic [ADDR_WIDTH-1:0] offset;

  // An empty or inverted window (start >= end) is how a window is disabled.
  always_comb begin
    for (int i = 0; i < NUM_WINDOWS; i++) begin
      hit[i] = ram_we && (win_lo[i] < win_hi[i]) &&
               (ram_addr >= win_lo[i]) && (ram_addr < win_hi[i]);
    end
  end

  // Scanning downward leaves the lowest-index hit in place.
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    hit_base = '0;
    for (int i = NUM_WINDOWS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any  = 1'b1;
        hit_idx  = IW'(i);
        hit_base = win_lo[i];
      end
    end
    offset = ram_addr - hit_base;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_WINDOWS; i++) begin
        win_lo[i] <= '0;
        win_hi[i] <= '0;
      end
      mirror_we   <= 1'b0;
      mirror_sel  <= '0;
      mirror_addr <= '0;
      mirror_din  <= '0;
    end else begin
      mirror_we <= hit_any;
      if (hit_any) begin
        mirror_sel  <= hit_idx;
        mirror_addr <= offset[MIRROR_AW-1:0];
        mirror_din  <= ram_din;
      end
      if (win_wr) begin
        win_lo[win_idx] <= win_start;
        win_hi[win_idx] <= win_end;
      end
    end
  end

endmodule

// File: rtl/mem_bus_sequencer.sv
// Shared SRAM port owner: a mode FSM hands the port between the flash loader,
// the CPU and the diagnostics engine, and feeds the video RAM mirror windows.
module mem_bus_sequencer
  import mem_bus_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_WINDOWS = 4,
  parameter int MIRROR_AW   = 11,
  parameter int HALT_SETTLE = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               load_done,
  input  logic [ADDR_WIDTH-1:0]              ld_addr,
  input  logic [DATA_WIDTH-1:0]              ld_din,
  input  logic                               ld_cs,
  input  logic                               ld_we,
  input  logic [ADDR_WIDTH-1:0]              cpu_addr,
  input  logic [DATA_WIDTH-1:0]              cpu_din,
  input  logic                               cpu_cs,
  input  logic                               cpu_we,
  input  logic                               cpu_cycle_active,
  input  logic                               halt_req,
  input  logic [ADDR_WIDTH-1:0]              dg_addr,
  input  logic [DATA_WIDTH-1:0]              dg_din,
  input  logic                               dg_cs,
  input  logic                               dg_we,
  output logic [ADDR_WIDTH-1:0]              ram_addr,
  output logic [DATA_WIDTH-1:0]              ram_din,
  output logic                               ram_cs,
  output logic                               ram_we,
  output logic                               cpu_rdy,
  output logic                               halt_ack,
  output logic                               data_out_en,
  input  logic                               win_wr,
  input  logic [idx_width(NUM_WINDOWS)-1:0]  win_idx,
  input  logic [ADDR_WIDTH-1:0]              win_start,
  input  logic [ADDR_WIDTH-1:0]              win_end,
  output logic                               mirror_we,
  output logic [idx_width(NUM_WINDOWS)-1:0]  mirror_sel,
  output logic [MIRROR_AW-1:0]               mirror_addr,
  output logic [DATA_WIDTH-1:0]              mirror_din
);

  localparam int CW = $clog2(HALT_SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_MAX = CW'(HALT_SETTLE);

  seq_state_t    state, next_state;
  logic [CW-1:0] settle_cnt, settle_next;

  // Status outputs are registered from next_state so they change on the
  // same edge as the mode itself.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= LOAD;
      settle_cnt  <= '0;
      cpu_rdy     <= 1'b0;
      halt_ack    <= 1'b0;
      data_out_en <= 1'b0;
    end else begin
      state       <= next_state;
      settle_cnt  <= settle_next;
      cpu_rdy     <= (next_state == RUN);
      halt_ack    <= (next_state == HALTED);
      data_out_en <= (next_state == RUN) || (next_state == HALT_WAIT);
    end
  end

  // Losing load_done sends every mode back to LOAD ahead of any halt request.
  always_comb begin
    next_state = state;
    case (state)
      LOAD:      if (load_done) next_state = RUN;
      RUN:       if (halt_req) next_state = HALT_WAIT;
      HALT_WAIT: begin
        if (settle_cnt == SETTLE_MAX) next_state = HALTED;
        else if (!halt_req)           next_state = RUN;
      end
      HALTED:    if (!halt_req) next_state = RESUME;
      RESUME:    next_state = RUN;
      default:   next_state = LOAD;
    endcase
    if (state != LOAD && !load_done) next_state = LOAD;

    settle_next = '0;
    if (state == HALT_WAIT && next_state == HALT_WAIT)
      settle_next = cpu_cycle_active ? '0 : settle_cnt + CW'(1);
  end

  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_din;
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    case (state)
      LOAD: begin
        ram_addr = ld_addr;
        ram_din  = ld_din;
        ram_cs   = ld_cs;
        ram_we   = ld_we;
      end
      RUN, HALT_WAIT: begin
        ram_cs = cpu_cs;
        ram_we = cpu_we;
      end
      HALTED: begin
        ram_addr = dg_addr;
        ram_din  = dg_din;
        ram_cs   = dg_cs;
        ram_we   = dg_we;
      end
      default: begin
        ram_cs = 1'b0;
        ram_we = 1'b0;
      end
    endcase
  end

  mirror_window_match #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_WINDOWS(NUM_WINDOWS),
    .MIRROR_AW  (MIRROR_AW)
  ) u_match (
    .clk        (clk),
    .reset      (reset),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .win_wr     (win_wr),
    .win_idx    (win_idx),
    .win_start  (win_start),
    .win_end    (win_end),
    .mirror_we  (mirror_we),
    .mirror_sel (mirror_sel),
    .mirror_addr(mirror_addr),
    .mirror_din (mirror_din)
  );

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Bench for mem_bus_sequencer: directed mode sequences, a window/mirror
// vector table, then randomized traffic against a behavioural model.
module tb_mem_bus_sequencer;

  localparam int HS = 3;
  localparam int M_LOAD = 0, M_RUN = 1, M_HW = 2, M_HALTED = 3, M_RESUME = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_done = 1'b0;
  logic [15:0] ld_addr = '0, cpu_addr = '0, dg_addr = '0;
  logic [7:0]  ld_din = '0, cpu_din = '0, dg_din = '0;
  logic        ld_cs = 1'b0, ld_we = 1'b0, cpu_cs = 1'b0, cpu_we = 1'b0;
  logic        dg_cs = 1'b0, dg_we = 1'b0;
  logic        cpu_cycle_active = 1'b0, halt_req = 1'b0;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_cs, ram_we, cpu_rdy, halt_ack, data_out_en;
  logic        win_wr = 1'b0;
  logic [1:0]  win_idx = '0;
  logic [15:0] win_start = '0, win_end = '0;
  logic        mirror_we;
  logic [1:0]  mirror_sel;
  logic [10:0] mirror_addr;
  logic [7:0]  mirror_din;

  int n_tests = 0;
  int n_fail = 0;
  logic random_checks = 1'b0;

  // Reference model state
  int          m_mode = M_LOAD;
  int          m_idle = 0;
  logic [15:0] m_lo [4] = '{default: '0};
  logic [15:0] m_hi [4] = '{default: '0};
  logic        m_mwe = 1'b0;
  logic [1:0]  m_sel = '0;
  logic [10:0] m_maddr = '0;
  logic [7:0]  m_mdin = '0;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  din;
    logic        we;
    logic        exp_mwe;
    logic [1:0]  exp_sel;
    logic [10:0] exp_maddr;
    logic [7:0]  exp_mdin;
  } vec_t;

  vec_t vecs [12];

  mem_bus_sequencer #(
    .ADDR_WIDTH(16), .DATA_WIDTH(8), .NUM_WINDOWS(4), .MIRROR_AW(11), .HALT_SETTLE(HS)
  ) dut (
    .clk(clk), .reset(reset), .load_done(load_done),
    .ld_addr(ld_addr), .ld_din(ld_din), .ld_cs(ld_cs), .ld_we(ld_we),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_cs(cpu_cs), .cpu_we(cpu_we),
    .cpu_cycle_active(cpu_cycle_active), .halt_req(halt_req),
    .dg_addr(dg_addr), .dg_din(dg_din), .dg_cs(dg_cs), .dg_we(dg_we),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_cs(ram_cs), .ram_we(ram_we),
    .cpu_rdy(cpu_rdy), .halt_ack(halt_ack), .data_out_en(data_out_en),
    .win_wr(win_wr), .win_idx(win_idx), .win_start(win_start), .win_end(win_end),
    .mirror_we(mirror_we), .mirror_sel(mirror_sel),
    .mirror_addr(mirror_addr), .mirror_din(mirror_din)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Which master the model says owns the RAM port right now.
  task automatic expRam(output logic [15:0] a, output logic [7:0] d, output logic c, output logic w);
    a = cpu_addr; d = cpu_din; c = 1'b0; w = 1'b0;
    case (m_mode)
      M_LOAD:     begin a = ld_addr; d = ld_din; c = ld_cs; w = ld_we; end
      M_RUN, M_HW: begin c = cpu_cs; w = cpu_we; end
      M_HALTED:   begin a = dg_addr; d = dg_din; c = dg_cs; w = dg_we; end
      default:    begin c = 1'b0; w = 1'b0; end
    endcase
  endtask

  task automatic checkRegs();
    checkOutput("cpu_rdy", cpu_rdy, m_mode == M_RUN);
    checkOutput("halt_ack", halt_ack, m_mode == M_HALTED);
    if (m_mode == M_LOAD || m_mode == M_RUN || m_mode == M_HALTED)
      checkOutput("data_out_en", data_out_en, m_mode == M_RUN);
    checkOutput("mirror_we", mirror_we, m_mwe);
    checkOutput("mirror_sel", mirror_sel, m_sel);
    checkOutput("mirror_addr", mirror_addr, m_maddr);
    checkOutput("mirror_din", mirror_din, m_mdin);
  endtask

  // One clock: settle inputs, step the model across the edge, sample at +1.
  task automatic tick();
    logic [15:0] ea;
    logic [7:0]  ed;
    logic        ec, ew;
    int          hit, nmode, nidle;
    #1;
    expRam(ea, ed, ec, ew);
    if (random_checks) begin
      checkOutput("ram_cs", ram_cs, ec);
      checkOutput("ram_we", ram_we, ew);
      if (m_mode != M_RESUME) begin
        checkOutput("ram_addr", ram_addr, ea);
        checkOutput("ram_din", ram_din, ed);
      end
    end
    if (!reset) begin
      nmode = M_LOAD; nidle = 0;
      m_lo = '{default: '0}; m_hi = '{default: '0};
      m_mwe = 1'b0; m_sel = '0; m_maddr = '0; m_mdin = '0;
    end else begin
      hit = -1;
      for (int i = 0; i < 4; i++)
        if (hit < 0 && ew && m_lo[i] < m_hi[i] && ea >= m_lo[i] && ea < m_hi[i]) hit = i;
      m_mwe = (hit >= 0);
      if (hit >= 0) begin
        m_sel = 2'(hit);
        m_maddr = 11'(ea - m_lo[hit]);
        m_mdin = ed;
      end
      if (win_wr) begin
        m_lo[win_idx] = win_start;
        m_hi[win_idx] = win_end;
      end
      nmode = m_mode;
      case (m_mode)
        M_LOAD:   if (load_done) nmode = M_RUN;
        M_RUN:    if (halt_req) nmode = M_HW;
        M_HW:     if (m_idle >= HS) nmode = M_HALTED; else if (!halt_req) nmode = M_RUN;
        M_HALTED: if (!halt_req) nmode = M_RESUME;
        default:  nmode = M_RUN;
      endcase
      if (m_mode != M_LOAD && !load_done) nmode = M_LOAD;
      nidle = (m_mode == M_HW && nmode == M_HW) ? (cpu_cycle_active ? 0 : m_idle + 1) : 0;
    end
    @(posedge clk);
    #1;
    m_mode = nmode;
    m_idle = nidle;
    if (random_checks) checkRegs();
  endtask

  task automatic writeWindow(input logic [1:0] idx, input logic [15:0] s, input logic [15:0] e);
    win_wr = 1'b1; win_idx = idx; win_start = s; win_end = e;
    cpu_we = 1'b0;
    tick();
    win_wr = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    cpu_addr = v.addr; cpu_din = v.din; cpu_we = v.we; cpu_cs = 1'b1;
    #1;
    checkOutput("mux_cpu_addr", ram_addr, v.addr);
    checkOutput("mux_cpu_we", ram_we, v.we);
    tick();
    checkOutput("tbl_mirror_we", mirror_we, v.exp_mwe);
    checkOutput("tbl_mirror_sel", mirror_sel, v.exp_sel);
    checkOutput("tbl_mirror_addr", mirror_addr, v.exp_maddr);
    checkOutput("tbl_mirror_din", mirror_din, v.exp_mdin);
  endtask

  function automatic logic [15:0] randAddr();
    if ($urandom_range(0, 7) == 0) return 16'hFFFF;
    return 16'(16'h8000 + $urandom_range(0, 16'h1FFF));
  endfunction

  initial begin
    vecs[0]  = '{16'h8500, 8'hAA, 1'b1, 1'b1, 2'd0, 11'h500, 8'hAA};
    vecs[1]  = '{16'h8400, 8'h5C, 1'b1, 1'b1, 2'd0, 11'h400, 8'h5C};
    vecs[2]  = '{16'h8900, 8'h55, 1'b1, 1'b1, 2'd1, 11'h500, 8'h55};
    vecs[3]  = '{16'h8000, 8'h11, 1'b1, 1'b1, 2'd0, 11'h000, 8'h11};
    vecs[4]  = '{16'h87FF, 8'h22, 1'b1, 1'b1, 2'd0, 11'h7FF, 8'h22};
    vecs[5]  = '{16'h8800, 8'h33, 1'b1, 1'b1, 2'd1, 11'h400, 8'h33};
    vecs[6]  = '{16'h8FFF, 8'h44, 1'b1, 1'b1, 2'd1, 11'h3FF, 8'h44};
    vecs[7]  = '{16'h9000, 8'h77, 1'b1, 1'b0, 2'd1, 11'h3FF, 8'h44};
    vecs[8]  = '{16'h7FFF, 8'h78, 1'b1, 1'b0, 2'd1, 11'h3FF, 8'h44};
    vecs[9]  = '{16'h8500, 8'h79, 1'b0, 1'b0, 2'd1, 11'h3FF, 8'h44};
    vecs[10] = '{16'hFFFF, 8'h7A, 1'b1, 1'b0, 2'd1, 11'h3FF, 8'h44};
    vecs[11] = '{16'hE84C, 8'h7B, 1'b1, 1'b0, 2'd1, 11'h3FF, 8'h44};

    // Reset and loader phase
    reset = 1'b0;
    tick(); tick();
    checkOutput("rst_cpu_rdy", cpu_rdy, 0);
    checkOutput("rst_halt_ack", halt_ack, 0);
    checkOutput("rst_data_out_en", data_out_en, 0);
    checkOutput("rst_mirror_we", mirror_we, 0);
    checkOutput("rst_mirror_sel", mirror_sel, 0);
    checkOutput("rst_mirror_addr", mirror_addr, 0);
    checkOutput("rst_mirror_din", mirror_din, 0);
    reset = 1'b1;
    ld_addr = 16'h1234; ld_din = 8'h5A; ld_cs = 1'b1; ld_we = 1'b1;
    cpu_addr = 16'h2222;
    #1;
    checkOutput("load_ram_addr", ram_addr, 16'h1234);
    checkOutput("load_ram_din", ram_din, 8'h5A);
    checkOutput("load_ram_we", ram_we, 1);
    tick();
    checkOutput("load_cpu_rdy", cpu_rdy, 0);
    load_done = 1'b1;
    tick();
    checkOutput("run_cpu_rdy", cpu_rdy, 1);
    checkOutput("run_data_out_en", data_out_en, 1);
    ld_we = 1'b0;
    cpu_cs = 1'b1;
    #1;
    checkOutput("run_ram_addr", ram_addr, 16'h2222);

    // Halt handshake: bus busy 5 cycles, then 4 idle cycles to ack
    halt_req = 1'b1; cpu_cycle_active = 1'b1;
    tick();
    checkOutput("hw_cpu_rdy", cpu_rdy, 0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("hw_busy_halt_ack", halt_ack, 0);
    cpu_cycle_active = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checkOutput("hw_settle_halt_ack", halt_ack, 0);
    tick();
    checkOutput("halted_halt_ack", halt_ack, 1);
    checkOutput("halted_cpu_rdy", cpu_rdy, 0);
    checkOutput("halted_data_out_en", data_out_en, 0);
    dg_addr = 16'h4321; dg_din = 8'hC3; dg_cs = 1'b1;
    #1;
    checkOutput("halted_ram_addr", ram_addr, 16'h4321);
    checkOutput("halted_ram_din", ram_din, 8'hC3);

    // Resume: one dead cycle on the RAM port
    cpu_we = 1'b1; dg_we = 1'b1;
    halt_req = 1'b0;
    tick();
    checkOutput("resume_ram_cs", ram_cs, 0);
    checkOutput("resume_ram_we", ram_we, 0);
    checkOutput("resume_halt_ack", halt_ack, 0);
    checkOutput("resume_cpu_rdy", cpu_rdy, 0);
    tick();
    checkOutput("rerun_cpu_rdy", cpu_rdy, 1);
    checkOutput("rerun_ram_cs", ram_cs, 1);
    dg_we = 1'b0;

    // Mirror window table
    writeWindow(2'd0, 16'h8000, 16'h8800);
    writeWindow(2'd1, 16'h8400, 16'h9000);
    writeWindow(2'd2, 16'hE84C, 16'hE84C);
    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // Window written in the same cycle as a matching write uses old bounds
    win_wr = 1'b1; win_idx = 2'd3; win_start = 16'h0100; win_end = 16'h0200;
    cpu_addr = 16'h0150; cpu_din = 8'h9D; cpu_we = 1'b1;
    tick();
    win_wr = 1'b0;
    checkOutput("samecyc_mirror_we", mirror_we, 0);
    tick();
    checkOutput("newwin_mirror_we", mirror_we, 1);
    checkOutput("newwin_mirror_sel", mirror_sel, 3);
    checkOutput("newwin_mirror_addr", mirror_addr, 11'h050);
    checkOutput("newwin_mirror_din", mirror_din, 8'h9D);
    cpu_we = 1'b0;

    // load_done loss during HALT_WAIT returns to LOAD
    halt_req = 1'b1; cpu_cycle_active = 1'b1;
    tick();
    checkOutput("hw2_cpu_rdy", cpu_rdy, 0);
    load_done = 1'b0; ld_addr = 16'h0ABC;
    tick();
    checkOutput("drop_cpu_rdy", cpu_rdy, 0);
    checkOutput("drop_halt_ack", halt_ack, 0);
    checkOutput("drop_data_out_en", data_out_en, 0);
    #1;
    checkOutput("drop_ram_addr", ram_addr, 16'h0ABC);

    // Randomized traffic against the model, starting from a fresh reset
    halt_req = 1'b0; load_done = 1'b1;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    random_checks = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) != 0);
      load_done = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 15) == 0) halt_req = ~halt_req;
      cpu_cycle_active = ($urandom_range(0, 2) == 0);
      ld_addr = randAddr(); cpu_addr = randAddr(); dg_addr = randAddr();
      ld_din = 8'($urandom); cpu_din = 8'($urandom); dg_din = 8'($urandom);
      ld_cs = 1'($urandom); cpu_cs = 1'($urandom); dg_cs = 1'($urandom);
      ld_we = 1'($urandom); cpu_we = 1'($urandom); dg_we = 1'($urandom);
      win_wr = ($urandom_range(0, 9) == 0);
      win_idx = 2'($urandom);
      win_start = 16'(16'h8000 + $urandom_range(0, 16'h1FFF));
      if ($urandom_range(0, 1) == 0)
        win_end = 16'(win_start + $urandom_range(0, 16'h900));
      else
        win_end = 16'(16'h8000 + $urandom_range(0, 16'h1FFF));
      tick();
    end
    random_checks = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
